// File: rtl/dm_resp_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
interface dm_resp_if;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req_rd, req_wr, addr, wdata,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req_rd, req_wr, addr, wdata,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: captures one request, stalls the pipeline
// for LATENCY cycles, then completes with a one-cycle ack (err on illegal access).
module dm_resp #(
    parameter int unsigned NMEM    = 128,
    parameter int unsigned AW      = 7,
    parameter int unsigned LATENCY = 2
) (
    input  logic      clk,
    input  logic      reset,
    dm_resp_if.slave  bus
);
    localparam int unsigned MIW      = (NMEM > 1) ? $clog2(NMEM) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [AW:0] NMEM_W   = (AW + 1)'(NMEM);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_d;
    logic [3:0]    cnt, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          bad_q, bad_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [2**MIW];

    logic          pending;
    logic [AW-1:0] req_idx;
    logic          req_bad;
    logic          unused_addr;

    assign pending = bus.req_rd | bus.req_wr;
    assign req_idx = bus.addr[AW+1:2];
    assign req_bad = (bus.req_rd & bus.req_wr) | (bus.addr[1:0] != 2'b00) |
                     ({1'b0, req_idx} >= NMEM_W);
    assign unused_addr = &{1'b0, bus.addr[31:AW+2]};

    // Next-state, capture and registered-output computation.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    idx_d   = req_idx;
                    wdata_d = bus.wdata;
                    wr_d    = bus.req_wr;
                    bad_d   = req_bad;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_d = DONE;
                else             cnt_d   = cnt - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are precomputed so they appear registered in the DONE cycle.
        ack_d   = (state_d == DONE);
        err_d   = ack_d & bad_d;
        rdata_d = (ack_d && !wr_d && !bad_d) ? mem[idx_d[MIW-1:0]] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Write commits on the edge leaving DONE; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (!reset && state == DONE && wr_q && !bad_q) begin
            mem[idx_q[MIW-1:0]] <= wdata_q;
        end
    end

    assign bus.busy  = ((state == IDLE) & pending) | (state == WAIT);
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule
